mux_2_1_arbiter: RTL and testbench
==================================

Name: mux_2_1_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 2:1 select datapath. Two valid/ready requesters, i0 and i1, compete for a single registered output stream y. The block drives the mux select from its grant state machine. It bounds how long one requester can monopolise the path, and registers the output for timing.

Parameters:
WIDTH, 8, data width of i0_data, i1_data, y_data
MAX_HOLD, 4, max consecutive transfers for one requester while the other is waiting (legal range 1..255)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
i0_valid  input  1  requester 0 has data
i0_data  input  WIDTH  requester 0 payload
i0_ready  output  1  requester 0 transfer accepted this cycle
i1_valid  input  1  requester 1 has data
i1_data  input  WIDTH  requester 1 payload
i1_ready  output  1  requester 1 transfer accepted this cycle
y_valid  output  1  registered output valid
y_data  output  WIDTH  registered output payload
y_ready  input  1  downstream accepts y
select  output  1  current grant / mux select (0 = i0, 1 = i1)
busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. rst has priority over all other activity.
- Reset values:
  - State: IDLE, select=0, busy=0, y_valid=0, y_data=0.
  - Internal: hold_cnt=0, last_served=1 (so i0 wins the first tie).
  - i0_ready=0 and i1_ready=0 follow from IDLE.
- Internal signals:
  - out_free = !y_valid || y_ready.
  - i0_ready = (state==GRANT0) && out_free. i1_ready = (state==GRANT1) && out_free. Both are combinational.
  - A transfer is ix_valid && ix_ready.
- Register updates each edge:
  - On a transfer: y_data <= granted data and y_valid <= 1.
  - Else if y_valid && y_ready: y_valid <= 0.
  - y_data is unchanged when nothing loads.
- Throughput and latency:
  - One beat per cycle while y_ready=1.
  - Latency is 1 cycle from transfer to y_valid.
- select equals 1 in GRANT1 and 0 in GRANT0. In IDLE it holds its last value.
- States: IDLE, GRANT0, GRANT1.
- IDLE transitions (no transfer occurs in IDLE, so leaving IDLE costs one bubble cycle):
  - Only i0_valid: go to GRANT0.
  - Only i1_valid: go to GRANT1.
  - Both valid: grant the requester != last_served.
  - Neither valid: stay.
- GRANTn transitions, evaluated every edge, in priority order:
  1. in_valid=0: go to GRANT(other) if the other is valid, else IDLE. No transfer occurs that cycle.
  2. A transfer occurs with hold_cnt==MAX_HOLD-1 and the other valid: go to GRANT(other) and clear hold_cnt. The switch has no bubble; the other may transfer the very next cycle.
  3. A transfer occurs with hold_cnt==MAX_HOLD-1 and the other not valid: stay in GRANTn and clear hold_cnt.
  4. Any other transfer: hold_cnt+1.
  5. No transfer (backpressure): hold everything.
- hold_cnt rules:
  - Cleared on every grant change, including entry from IDLE.
  - Width is clog2(MAX_HOLD), minimum 1 bit.
- last_served <= n on every transfer from requester n.
- MAX_HOLD=1: strict alternation whenever both requesters are valid.
- Requester dropping valid: a requester may deassert valid at any time. Data is not taken unless valid && ready in the same cycle.
- Reset mid-operation:
  - The pending y beat is discarded (y_valid=0 the cycle after rst).
  - The in-progress grant and hold count are discarded; the first tie after reset goes to i0.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with both valids high -> y_valid=0, y_data=0, select=0, busy=0, i0_ready=i1_ready=0. Release -> first grant is GRANT0.
2. Single requester: i0_valid=1 with data 0x11, 0x22, 0x33 presented on accept, y_ready=1 -> IDLE bubble, then i0_ready high 3 cycles, y_data 0x11/0x22/0x33 on consecutive cycles, select=0, then IDLE.
3. Contention, MAX_HOLD=4: both valid continuously, y_ready=1 -> y_data sequence of 4 i0 beats, 4 i1 beats, 4 i0 beats. select toggles every 4 cycles with no bubble at the switches.
4. Backpressure: during GRANT0, y_ready=0 for 3 cycles with y_valid=1 -> y_data held, i0_ready=0, hold_cnt frozen. Release y_ready -> transfers resume and the count continues (switch still after 4 total beats).
5. Fairness from IDLE: serve one i0 beat, go idle, then assert both valids the same cycle -> GRANT1 is taken first.
6. Reset mid-burst: rst=1 while in GRANT1 with y_valid=1 -> next cycle y_valid=0, state IDLE, select=0. A subsequent tie grants i0.

Source files
------------

// File: rtl/mux_2_1_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing one registered
// output stream. The grant FSM drives the mux select. A hold counter limits
// how many back-to-back beats one side may take while the other is waiting.
module mux_2_1_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             select,
  output logic             busy
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } state_e;

  state_e          state;
  logic [CntW-1:0] hold_cnt;
  logic            last_served;

  logic out_free;
  logic xfer0;
  logic xfer1;
  logic hold_done;

  // The output register can take a new beat when empty or draining this cycle
  assign out_free  = !y_valid || y_ready;
  assign i0_ready  = (state == StGrant0) && out_free;
  assign i1_ready  = (state == StGrant1) && out_free;
  assign xfer0     = i0_valid && i0_ready;
  assign xfer1     = i1_valid && i1_ready;
  assign hold_done = (hold_cnt == HoldLast);
  assign busy      = (state != StIdle);

  // Grant FSM, hold counter, fairness bit and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      select      <= 1'b0;
      hold_cnt    <= '0;
      last_served <= 1'b1;  // i0 wins the first tie
      y_valid     <= 1'b0;
      y_data      <= '0;
    end else begin
      // Output stage
      if (xfer0) begin
        y_data  <= i0_data;
        y_valid <= 1'b1;
      end else if (xfer1) begin
        y_data  <= i1_data;
        y_valid <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end

      case (state)
        StIdle: begin
          // No transfer here; entering a grant costs one bubble cycle
          hold_cnt <= '0;
          if (i0_valid && (!i1_valid || last_served)) begin
            state  <= StGrant0;
            select <= 1'b0;
          end else if (i1_valid) begin
            state  <= StGrant1;
            select <= 1'b1;
          end
        end

        StGrant0: begin
          if (!i0_valid) begin
            hold_cnt <= '0;
            if (i1_valid) begin
              state  <= StGrant1;
              select <= 1'b1;
            end else begin
              state <= StIdle;
            end
          end else if (xfer0) begin
            last_served <= 1'b0;
            if (hold_done) begin
              // Quota used up: hand over without a bubble if i1 is waiting
              hold_cnt <= '0;
              if (i1_valid) begin
                state  <= StGrant1;
                select <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        StGrant1: begin
          if (!i1_valid) begin
            hold_cnt <= '0;
            if (i0_valid) begin
              state  <= StGrant0;
              select <= 1'b0;
            end else begin
              state <= StIdle;
            end
          end else if (xfer1) begin
            last_served <= 1'b1;
            if (hold_done) begin
              hold_cnt <= '0;
              if (i0_valid) begin
                state  <= StGrant0;
                select <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= StIdle;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed bench for mux_2_1_arbiter with WIDTH=8, MAX_HOLD=4.
module tb_mux_2_1_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i0_valid;
  logic [WIDTH-1:0] i0_data;
  logic             i0_ready;
  logic             i1_valid;
  logic [WIDTH-1:0] i1_data;
  logic             i1_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             select;
  logic             busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] n0;
  logic [7:0] n1;

  // {y_valid, select, busy, i0_ready, i1_ready}
  logic [4:0] st;
  assign st = {y_valid, select, busy, i0_ready, i1_ready};

  mux_2_1_arbiter #(
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i0_valid(i0_valid),
    .i0_data (i0_data),
    .i0_ready(i0_ready),
    .i1_valid(i1_valid),
    .i1_data (i1_data),
    .i1_ready(i1_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .select  (select),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; count accepted beats so the sources present next data
  task automatic tick();
    logic a0;
    logic a1;
    #1;
    a0 = i0_valid && i0_ready;
    a1 = i1_valid && i1_ready;
    @(posedge clk);
    #1;
    if (a0 === 1'b1) n0 = n0 + 8'd1;
    if (a1 === 1'b1) n1 = n1 + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i0_valid = 1'b1; i1_valid = 1'b1;
    i0_data = 8'h5A; i1_data = 8'hA5; y_ready = 1'b1;
    n0 = 8'd0; n1 = 8'd0;
    tick(); tick();
    total++;
    if (st !== 5'b00000) begin
      bad++; $display("FAIL reset_status got=%b exp=%b", st, 5'b00000);
    end
    total++;
    if (y_data !== 8'h00) begin
      bad++; $display("FAIL reset_y_data got=%h exp=%h", y_data, 8'h00);
    end
    rst = 1'b0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL reset_first_grant got=%b exp=%b", st, 5'b00110);
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00000) begin
      bad++; $display("FAIL reset_back_idle got=%b exp=%b", st, 5'b00000);
    end
  endtask

  task automatic test_contention();
    logic [7:0]  exp_y [12];
    logic [11:0] exp_sel;
    exp_y = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
              8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    exp_sel = 12'b1000_0111_1000;
    n0 = 8'd0; n1 = 8'd0;
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'hA0; i1_data = 8'hB0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL contention_grant0 got=%b exp=%b", st, 5'b00110);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      i0_data = 8'hA0 + n0;
      i1_data = 8'hB0 + n1;
      total++;
      if (y_data !== exp_y[k] || {y_valid, select} !== {1'b1, exp_sel[k]}) begin
        bad++;
        $display("FAIL contention_beat%0d got y=%h v=%b sel=%b exp y=%h v=1 sel=%b",
                 k, y_data, y_valid, select, exp_y[k], exp_sel[k]);
      end
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b01000) begin
      bad++; $display("FAIL contention_idle got=%b exp=%b", st, 5'b01000);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_y [3];
    exp_y = '{8'h11, 8'h22, 8'h33};
    n0 = 8'd0; n1 = 8'd0;
    i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL single_bubble got=%b exp=%b", st, 5'b00110);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      i0_data = 8'h11 * (n0 + 8'd1);
      total++;
      if (y_data !== exp_y[k] || st !== 5'b10110) begin
        bad++;
        $display("FAIL single_beat%0d got y=%h st=%b exp y=%h st=%b",
                 k, y_data, st, exp_y[k], 5'b10110);
      end
    end
    i0_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00000 || y_data !== 8'h33) begin
      bad++;
      $display("FAIL single_idle got st=%b y=%h exp st=%b y=%h", st, y_data, 5'b00000, 8'h33);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_y [4];
    logic [3:0] exp_sel;
    exp_y = '{8'hC1, 8'hC2, 8'hC3, 8'hD0};
    exp_sel = 4'b1100;
    n0 = 8'd0; n1 = 8'd0;
    i0_valid = 1'b1; i0_data = 8'hC0; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL bp_grant0 got=%b exp=%b", st, 5'b00110);
    end
    i1_valid = 1'b1; i1_data = 8'hD0;
    tick();
    i0_data = 8'hC0 + n0;
    total++;
    if (y_data !== 8'hC0 || st !== 5'b10110) begin
      bad++;
      $display("FAIL bp_first got y=%h st=%b exp y=%h st=%b", y_data, st, 8'hC0, 5'b10110);
    end
    y_ready = 1'b0;
    #1;
    total++;
    if (st !== 5'b10100) begin
      bad++; $display("FAIL bp_ready_drop got=%b exp=%b", st, 5'b10100);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (y_data !== 8'hC0 || st !== 5'b10100) begin
        bad++;
        $display("FAIL bp_stall%0d got y=%h st=%b exp y=%h st=%b",
                 k, y_data, st, 8'hC0, 5'b10100);
      end
    end
    y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      i0_data = 8'hC0 + n0;
      i1_data = 8'hD0 + n1;
      total++;
      if (y_data !== exp_y[k] || {y_valid, select} !== {1'b1, exp_sel[k]}) begin
        bad++;
        $display("FAIL bp_resume%0d got y=%h v=%b sel=%b exp y=%h v=1 sel=%b",
                 k, y_data, y_valid, select, exp_y[k], exp_sel[k]);
      end
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b01000) begin
      bad++; $display("FAIL bp_idle got=%b exp=%b", st, 5'b01000);
    end
  endtask

  task automatic test_fairness();
    i0_valid = 1'b1; i0_data = 8'h44; i1_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL fair_grant0 got=%b exp=%b", st, 5'b00110);
    end
    tick();
    total++;
    if (y_data !== 8'h44 || st !== 5'b10110) begin
      bad++;
      $display("FAIL fair_beat got y=%h st=%b exp y=%h st=%b", y_data, st, 8'h44, 5'b10110);
    end
    i0_valid = 1'b0;
    tick();
    total++;
    if (st !== 5'b00000) begin
      bad++; $display("FAIL fair_idle got=%b exp=%b", st, 5'b00000);
    end
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'h66; i1_data = 8'h55;
    tick();
    total++;
    if (st !== 5'b01101) begin
      bad++; $display("FAIL fair_tie_grant1 got=%b exp=%b", st, 5'b01101);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    total++;
    if (y_data !== 8'h55 || st !== 5'b11101) begin
      bad++;
      $display("FAIL midrst_beat got y=%h st=%b exp y=%h st=%b", y_data, st, 8'h55, 5'b11101);
    end
    rst = 1'b1;
    tick();
    total++;
    if (st !== 5'b00000 || y_data !== 8'h00) begin
      bad++;
      $display("FAIL midrst_cleared got st=%b y=%h exp st=%b y=%h", st, y_data, 5'b00000, 8'h00);
    end
    rst = 1'b0;
    tick();
    total++;
    if (st !== 5'b00110) begin
      bad++; $display("FAIL midrst_tie_grant0 got=%b exp=%b", st, 5'b00110);
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
